instr_trace_buffer: RTL and testbench
=====================================

INSTR_TRACE_BUFFER -- requirements
Module: instr_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, trace entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter OVERWRITE, default 0: 0 = drop new entry when full, 1 = overwrite oldest entry when full.
REQ-003 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  capture enable; when low, in_valid is ignored.
REQ-007 in_valid  in  1  one retired instruction presented this cycle.
REQ-008 in_pc  in  32  PC of the retired instruction.
REQ-009 in_instr  in  32  instruction word.
REQ-010 out_valid  out  1  head entry available (not empty).
REQ-011 out_ready  in  1  consumer accepts the head entry this cycle.
REQ-012 out_pc, out_instr  out  32 each  head entry fields.
REQ-013 out_class  out  4  decoded class of head entry.
REQ-014 out_target  out  32  stored control-flow target of head entry.
REQ-015 count  out  AW+1  current occupancy, 0..DEPTH.
REQ-016 full, empty  out  1 each  count==DEPTH, count==0.
REQ-017 retire_cnt  out  32  accepted pushes since reset, wraps modulo 2^32.
REQ-018 drop_cnt  out  16  lost entries since reset, saturates at 16'hFFFF.

Function
REQ-019 Push = en & in_valid; pop = out_valid & out_ready.
REQ-020 Class decode at push (op=instr[31:26], func=instr[5:0]): op 0/func 100000 ->1 add; func 100010 ->2 sub; func 001000 ->3 jr; func 000000 ->0 nop; op 001101 ->4 ori; 100011 ->5 lw; 101011 ->6 sw; 000100 ->7 beq; 001111 ->8 lui; 000011 ->9 jal; anything else ->15 unknown.
REQ-021 Target at push: beq -> in_pc + 4 + (signext(imm16) << 2), modulo 2^32; jal -> {in_pc[31:28], instr[25:0], 2'b00}; all other classes -> 32'h0.
REQ-022 Storage: circular buffer, write/read pointers AW bits, wrap from DEPTH-1 to 0.
REQ-023 Output is show-ahead: head entry fields driven combinationally from storage; entry pushed on edge k appears on outputs after edge k when buffer was empty.
REQ-024 Outputs when empty: out_valid=0; out_pc/out_instr/out_class/out_target values are don't-care.
REQ-025 Not full: push writes at write pointer, count+1, retire_cnt+1.
REQ-026 Push and pop same cycle, any occupancy including full: both performed, count unchanged, retire_cnt+1, drop_cnt unchanged.
REQ-027 Full, push without pop, OVERWRITE=0: entry discarded, storage and pointers unchanged, drop_cnt+1, retire_cnt unchanged.
REQ-028 Full, push without pop, OVERWRITE=1: oldest entry replaced, both pointers advance, count stays DEPTH, retire_cnt+1, drop_cnt+1.
REQ-029 Pop without push: read pointer advances, count-1.
REQ-030 out_ready while empty: no state change.
REQ-031 en low: no push, no counter change; pops continue normally.
REQ-032 drop_cnt at 16'hFFFF stays 16'hFFFF on further drops.

Reset
REQ-033 reset high asynchronously forces pointers=0, count=0, empty=1, full=0, out_valid=0, retire_cnt=0, drop_cnt=0, regardless of clk.
REQ-034 Storage contents need not be cleared.
REQ-035 Reset mid-operation discards all entries; first push after reset release lands at index 0.
REQ-036 Push/pop on the first edge after reset deassertion are honoured normally.

Verification
REQ-037 Push 32'h3402_0005 (ori) at pc 32'h0000_3000, out_ready=0 -> out_valid=1, out_class=4, out_target=0, count=1, retire_cnt=1.
REQ-038 Push beq 32'h1022_FFFF at pc 32'h0000_3010 -> out_class=7, out_target=32'h0000_3010; push jal 32'h0C00_0C10 at pc 32'h0000_3014 -> popped entry class=9, target=32'h0000_3040.
REQ-039 DEPTH=4, OVERWRITE=0: push 6 distinct entries, no pops -> full=1, count=4, drop_cnt=2, retire_cnt=4, pops return entries 1..4 in order.
REQ-040 DEPTH=4, OVERWRITE=1: push 6 entries, no pops -> count=4, drop_cnt=2, retire_cnt=6, pops return entries 3..6 in order.
REQ-041 Full buffer, push+pop same cycle -> count stays DEPTH, drop_cnt unchanged, new entry at tail, head advances by one.
REQ-042 Assert reset between clock edges with 3 entries held -> outputs go empty immediately, counters 0; next push appears at head with count=1.

Source files
------------

// File: rtl/instr_trace_buffer.sv
// Retired-instruction trace FIFO with class/target decode at capture time.
// Head entry is shown ahead; a full buffer either drops or overwrites the oldest entry.
module instr_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter bit OVERWRITE = 1'b0,
  parameter int AW        = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic [3:0]    out_class,
  output logic [31:0]   out_target,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [31:0]   retire_cnt,
  output logic [15:0]   drop_cnt
);

  localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P  = AW'(1);

  logic [31:0] pc_mem  [DEPTH];
  logic [31:0] ins_mem [DEPTH];
  logic [31:0] tgt_mem [DEPTH];
  logic [3:0]  cls_mem [DEPTH];

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   ret_q, ret_d;
  logic [15:0]   drop_q, drop_d;

  logic        push, pop, we, drop_inc;
  logic [5:0]  op, func;
  logic [3:0]  cls;
  logic [31:0] tgt, boff;

  assign push = en & in_valid;
  assign pop  = out_valid & out_ready;
  assign op   = in_instr[31:26];
  assign func = in_instr[5:0];
  assign boff = {{14{in_instr[15]}}, in_instr[15:0], 2'b00};

  always_comb begin
    cls = 4'd15;
    tgt = 32'h0;
    case (op)
      6'b000000: begin
        case (func)
          6'b100000: cls = 4'd1;
          6'b100010: cls = 4'd2;
          6'b001000: cls = 4'd3;
          6'b000000: cls = 4'd0;
          default:   cls = 4'd15;
        endcase
      end
      6'b001101: cls = 4'd4;
      6'b100011: cls = 4'd5;
      6'b101011: cls = 4'd6;
      6'b000100: begin
        cls = 4'd7;
        tgt = in_pc + 32'd4 + boff;
      end
      6'b001111: cls = 4'd8;
      6'b000011: begin
        cls = 4'd9;
        tgt = {in_pc[31:28], in_instr[25:0], 2'b00};
      end
      default:   cls = 4'd15;
    endcase
  end

  // When full, wr_q == rd_q, so an overwrite lands on the oldest entry.
  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    ret_d    = ret_q;
    we       = 1'b0;
    drop_inc = 1'b0;
    if (push) begin
      if (pop) begin
        we    = 1'b1;
        wr_d  = wr_q + ONE_P;
        rd_d  = rd_q + ONE_P;
        ret_d = ret_q + 32'd1;
      end else if (!full) begin
        we    = 1'b1;
        wr_d  = wr_q + ONE_P;
        cnt_d = cnt_q + ONE_C;
        ret_d = ret_q + 32'd1;
      end else if (OVERWRITE) begin
        we       = 1'b1;
        wr_d     = wr_q + ONE_P;
        rd_d     = rd_q + ONE_P;
        ret_d    = ret_q + 32'd1;
        drop_inc = 1'b1;
      end else begin
        drop_inc = 1'b1;
      end
    end else if (pop) begin
      rd_d  = rd_q + ONE_P;
      cnt_d = cnt_q - ONE_C;
    end
    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ret_q  <= '0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ret_q  <= ret_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      pc_mem[wr_q]  <= in_pc;
      ins_mem[wr_q] <= in_instr;
      tgt_mem[wr_q] <= tgt;
      cls_mem[wr_q] <= cls;
    end
  end

  assign out_valid  = (cnt_q != '0);
  assign out_pc     = pc_mem[rd_q];
  assign out_instr  = ins_mem[rd_q];
  assign out_class  = cls_mem[rd_q];
  assign out_target = tgt_mem[rd_q];
  assign count      = cnt_q;
  assign full       = (cnt_q == FULL_C);
  assign empty      = (cnt_q == '0);
  assign retire_cnt = ret_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Directed bench: three trace buffers (16 drop, 4 drop, 4 overwrite)
// checked every cycle against a queue scoreboard.
module tb_instr_trace_buffer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] tgt;
    logic [3:0]  cls;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc, in_instr;
  logic        en [3];
  logic        rdy [3];
  logic        ov [3];
  logic        fl [3];
  logic        em [3];
  logic [31:0] opc [3];
  logic [31:0] oin [3];
  logic [31:0] otg [3];
  logic [31:0] ret [3];
  logic [3:0]  ocl [3];
  logic [15:0] drp [3];
  logic [4:0]  c0;
  logic [2:0]  c1, c2;

  ent_t q0[$], q1[$], q2[$];
  int   exp_ret [3];
  int   exp_drp [3];
  int   dep [3] = '{16, 4, 4};
  bit   ow [3]  = '{1'b0, 1'b0, 1'b1};
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  instr_trace_buffer #(.DEPTH(16), .OVERWRITE(1'b0), .AW(4)) u0 (
    .clk(clk), .reset(reset), .en(en[0]), .in_valid(in_valid),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(ov[0]),
    .out_ready(rdy[0]), .out_pc(opc[0]), .out_instr(oin[0]),
    .out_class(ocl[0]), .out_target(otg[0]), .count(c0),
    .full(fl[0]), .empty(em[0]), .retire_cnt(ret[0]), .drop_cnt(drp[0])
  );

  instr_trace_buffer #(.DEPTH(4), .OVERWRITE(1'b0), .AW(2)) u1 (
    .clk(clk), .reset(reset), .en(en[1]), .in_valid(in_valid),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(ov[1]),
    .out_ready(rdy[1]), .out_pc(opc[1]), .out_instr(oin[1]),
    .out_class(ocl[1]), .out_target(otg[1]), .count(c1),
    .full(fl[1]), .empty(em[1]), .retire_cnt(ret[1]), .drop_cnt(drp[1])
  );

  instr_trace_buffer #(.DEPTH(4), .OVERWRITE(1'b1), .AW(2)) u2 (
    .clk(clk), .reset(reset), .en(en[2]), .in_valid(in_valid),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(ov[2]),
    .out_ready(rdy[2]), .out_pc(opc[2]), .out_instr(oin[2]),
    .out_class(ocl[2]), .out_target(otg[2]), .count(c2),
    .full(fl[2]), .empty(em[2]), .retire_cnt(ret[2]), .drop_cnt(drp[2])
  );

  function automatic ent_t mk(logic [31:0] pc, logic [31:0] ins,
                              logic [3:0] cls, logic [31:0] tgt);
    ent_t e;
    e.pc = pc; e.ins = ins; e.cls = cls; e.tgt = tgt;
    return e;
  endfunction

  function automatic int qsz(int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ent_t qfront(int d);
    case (d)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void qpush(int d, ent_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic void qpop(int d);
    ent_t e;
    case (d)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endfunction

  function automatic logic [31:0] cntv(int d);
    case (d)
      0: return {27'b0, c0};
      1: return {29'b0, c1};
      default: return {29'b0, c2};
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(int d);
    int   n;
    ent_t h;
    n = qsz(d);
    chk($sformatf("d%0d_count", d), cntv(d), 32'(n));
    chk($sformatf("d%0d_empty", d), {31'b0, em[d]}, {31'b0, n == 0});
    chk($sformatf("d%0d_full", d), {31'b0, fl[d]}, {31'b0, n == dep[d]});
    chk($sformatf("d%0d_out_valid", d), {31'b0, ov[d]}, {31'b0, n != 0});
    chk($sformatf("d%0d_retire", d), ret[d], 32'(exp_ret[d]));
    chk($sformatf("d%0d_drop", d), {16'b0, drp[d]}, 32'(exp_drp[d]));
    if (n > 0) begin
      h = qfront(d);
      chk($sformatf("d%0d_out_pc", d), opc[d], h.pc);
      chk($sformatf("d%0d_out_instr", d), oin[d], h.ins);
      chk($sformatf("d%0d_out_class", d), {28'b0, ocl[d]}, {28'b0, h.cls});
      chk($sformatf("d%0d_out_target", d), otg[d], h.tgt);
    end
  endtask

  // p: push, r: out_ready, eo: when not pushing, hold en=1 with in_valid=0
  // instead of the default en=0 with in_valid=1.
  task automatic cycle(int d, bit p, bit r, ent_t e, bit eo = 1'b0);
    int n;
    bit popv;
    n = qsz(d);
    popv = r && (n > 0);
    if (popv) qpop(d);
    if (p) begin
      if (popv || n < dep[d]) begin
        qpush(d, e);
        exp_ret[d]++;
      end else if (ow[d]) begin
        qpop(d);
        qpush(d, e);
        exp_ret[d]++;
        exp_drp[d]++;
      end else begin
        exp_drp[d]++;
      end
    end
    en[d]    = p ? 1'b1 : eo;
    in_valid = p ? 1'b1 : !eo;
    in_pc    = e.pc;
    in_instr = e.ins;
    rdy[d]   = r;
    @(posedge clk);
    #1;
    en[d]    = 1'b0;
    in_valid = 1'b0;
    rdy[d]   = 1'b0;
    check_state(d);
  endtask

  ent_t e_ori, e_beq, e_jal, e_add, e_sub, e_jr, e_nop, e_lw, e_sw;
  ent_t e_lui, e_unk1, e_unk2, e_beqf, e_beqw, e_jalh, e_x;

  initial begin
    e_ori  = mk(32'h0000_3000, 32'h3402_0005, 4'd4, 32'h0);
    e_beq  = mk(32'h0000_3010, 32'h1022_FFFF, 4'd7, 32'h0000_3010);
    e_jal  = mk(32'h0000_3014, 32'h0C00_0C10, 4'd9, 32'h0000_3040);
    e_add  = mk(32'h0000_0200, 32'h0000_0020, 4'd1, 32'h0);
    e_sub  = mk(32'h0000_0204, 32'h0000_0022, 4'd2, 32'h0);
    e_jr   = mk(32'h0000_0208, 32'h03E0_0008, 4'd3, 32'h0);
    e_nop  = mk(32'h0000_020C, 32'h0000_0000, 4'd0, 32'h0);
    e_lw   = mk(32'h0000_0210, 32'h8C01_0004, 4'd5, 32'h0);
    e_sw   = mk(32'h0000_0214, 32'hAC01_0004, 4'd6, 32'h0);
    e_lui  = mk(32'h0000_0218, 32'h3C01_1234, 4'd8, 32'h0);
    e_unk1 = mk(32'h0000_021C, 32'hFC00_0000, 4'd15, 32'h0);
    e_unk2 = mk(32'h0000_0220, 32'h0000_003F, 4'd15, 32'h0);
    e_beqf = mk(32'h0000_0100, 32'h1000_0003, 4'd7, 32'h0000_0110);
    e_beqw = mk(32'hFFFF_FFF8, 32'h1000_0001, 4'd7, 32'h0000_0000);
    e_jalh = mk(32'hA000_0000, 32'h0FFF_FFFF, 4'd9, 32'hAFFF_FFFC);
    e_x    = mk(32'hDEAD_0000, 32'h0000_0020, 4'd1, 32'h0);

    reset = 1'b1;
    in_valid = 1'b0;
    in_pc = '0;
    in_instr = '0;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0;
      rdy[i] = 1'b0;
      exp_ret[i] = 0;
      exp_drp[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_state(i);
    reset = 1'b0;

    // Deep buffer: decode coverage and show-ahead ordering
    cycle(0, 1, 0, e_ori);
    cycle(0, 1, 0, e_beq);
    cycle(0, 1, 0, e_jal);
    cycle(0, 0, 1, e_x);
    cycle(0, 0, 1, e_x);
    cycle(0, 1, 1, e_add);
    cycle(0, 1, 0, e_sub);
    cycle(0, 1, 0, e_jr);
    cycle(0, 1, 0, e_nop);
    cycle(0, 0, 0, e_x);
    cycle(0, 0, 0, e_x, 1'b1);
    cycle(0, 1, 1, e_lw);
    cycle(0, 1, 0, e_sw);
    cycle(0, 1, 1, e_lui);
    cycle(0, 1, 0, e_unk1);
    cycle(0, 1, 1, e_unk2);
    cycle(0, 1, 0, e_beqf);
    cycle(0, 1, 0, e_beqw);
    cycle(0, 1, 1, e_jalh);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, e_x);
    cycle(0, 0, 1, e_x);

    // Depth 4, drop on full
    for (int i = 1; i <= 6; i++)
      cycle(1, 1, 0, mk(32'h1000 + 32'(4 * i), 32'h8C01_0000 | 32'(i), 4'd5, 32'h0));
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, e_x);
    cycle(1, 0, 1, e_x);
    for (int i = 7; i <= 10; i++)
      cycle(1, 1, 0, mk(32'h1000 + 32'(4 * i), 32'hAC01_0000 | 32'(i), 4'd6, 32'h0));
    cycle(1, 1, 1, e_beqf);
    cycle(1, 1, 1, e_jalh);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, e_x);

    // Depth 4, overwrite oldest on full
    for (int i = 1; i <= 6; i++)
      cycle(2, 1, 0, mk(32'h2000 + 32'(4 * i), 32'h3C01_0000 | 32'(i), 4'd8, 32'h0));
    cycle(2, 1, 1, e_beq);
    for (int i = 0; i < 4; i++) cycle(2, 0, 1, e_x);

    // Asynchronous reset between edges with entries held
    cycle(0, 1, 0, e_add);
    cycle(0, 1, 0, e_sub);
    cycle(0, 1, 0, e_lw);
    cycle(1, 1, 0, e_sw);
    #2;
    reset = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    q2.delete();
    for (int i = 0; i < 3; i++) begin
      exp_ret[i] = 0;
      exp_drp[i] = 0;
      check_state(i);
    end
    #1;
    reset = 1'b0;
    cycle(0, 1, 0, e_jal);
    cycle(0, 1, 1, e_ori);
    cycle(0, 0, 1, e_x);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
